// File: rtl/orientation_filter.sv
// rtl/orientation_filter.sv - averaged range-pair heading estimator
// Averages 2^AVG_LOG2 distance pairs, maps |AVG1-AVG2| to an arctangent angle with deadband and saturation.
module orientation_filter #(
   parameter int DW       = 8,
   parameter int AVG_LOG2 = 2,
   parameter int DEADBAND = 0
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [DW-1:0] DIST1,
   input  logic [DW-1:0] DIST2,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [7:0]    ANGLE,
   output logic [1:0]    DIRECTION,
   output logic          SATURATED
);

   localparam int AW = DW + AVG_LOG2;
   localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam logic [DW-1:0] SAT_LIM = DW'(70);
   localparam logic [DW-1:0] DB_LIM  = DW'(DEADBAND);

   // round(atan(x/28)) in degrees for x = 0..70
   localparam logic [7:0] ATAN_LUT [0:70] = '{
      8'd0,  8'd2,  8'd4,  8'd6,  8'd8,  8'd10, 8'd12, 8'd14, 8'd16, 8'd18,
      8'd20, 8'd21, 8'd23, 8'd25, 8'd27, 8'd28, 8'd30, 8'd31, 8'd33, 8'd34,
      8'd36, 8'd37, 8'd38, 8'd39, 8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46,
      8'd47, 8'd48, 8'd49, 8'd50, 8'd51, 8'd51, 8'd52, 8'd53, 8'd54, 8'd54,
      8'd55, 8'd56, 8'd56, 8'd57, 8'd58, 8'd58, 8'd59, 8'd59, 8'd60, 8'd60,
      8'd61, 8'd61, 8'd62, 8'd62, 8'd63, 8'd63, 8'd63, 8'd64, 8'd64, 8'd65,
      8'd65, 8'd65, 8'd66, 8'd66, 8'd66, 8'd67, 8'd67, 8'd67, 8'd68, 8'd68,
      8'd68
   };

   typedef enum logic [1:0] {ACCUM, DIFF, LOOKUP, HOLD} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] acc1, acc2;
   logic [CW-1:0] cnt;
   logic [DW-1:0] x;
   logic [1:0]    dir;
   logic [DW-1:0] avg1, avg2, diff_abs;
   logic [1:0]    diff_dir;
   logic          last_sample;

   assign IN_READY    = RST_N && (state == ACCUM);
   assign last_sample = (AVG_LOG2 == 0) ? 1'b1 : (cnt == {CW{1'b1}});

   always_comb begin
      avg1     = DW'(acc1 >> AVG_LOG2);
      avg2     = DW'(acc2 >> AVG_LOG2);
      diff_abs = '0;
      diff_dir = 2'b00;
      if (avg1 > avg2) begin
         diff_abs = avg1 - avg2;
         diff_dir = 2'b10;
      end else if (avg1 < avg2) begin
         diff_abs = avg2 - avg1;
         diff_dir = 2'b01;
      end
      if (diff_abs <= DB_LIM) begin
         diff_abs = '0;
         diff_dir = 2'b00;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (IN_VALID && last_sample) state_nxt = DIFF;
         DIFF:    state_nxt = LOOKUP;
         LOOKUP:  state_nxt = HOLD;
         HOLD:    if (OUT_READY) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ACCUM;
         acc1      <= '0;
         acc2      <= '0;
         cnt       <= '0;
         x         <= '0;
         dir       <= 2'b00;
         ANGLE     <= 8'd0;
         DIRECTION <= 2'b00;
         SATURATED <= 1'b0;
         OUT_VALID <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ACCUM: if (IN_VALID) begin
               acc1 <= acc1 + AW'(DIST1);
               acc2 <= acc2 + AW'(DIST2);
               cnt  <= cnt + CW'(1);
            end
            DIFF: begin
               x   <= diff_abs;
               dir <= diff_dir;
            end
            LOOKUP: begin
               if (x > SAT_LIM) begin
                  ANGLE     <= 8'd68;
                  SATURATED <= 1'b1;
               end else begin
                  ANGLE     <= ATAN_LUT[x[6:0]];
                  SATURATED <= 1'b0;
               end
               DIRECTION <= dir;
               OUT_VALID <= 1'b1;
            end
            HOLD: if (OUT_READY) begin
               // result registers keep the last estimate; only the valid flag drops
               OUT_VALID <= 1'b0;
               acc1      <= '0;
               acc2      <= '0;
               cnt       <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_orientation_filter.sv
// tb/tb_orientation_filter.sv - scoreboard bench for orientation_filter
// Two instances: A averages 4 pairs with no deadband, B passes single pairs with deadband 2.
module tb_orientation_filter;

   typedef struct {
      int angle;
      int dir;
      int sat;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       v_a, rdy_a, ov_a, ordy_a, sat_a;
   logic [7:0] d1_a, d2_a, ang_a;
   logic [1:0] dir_a;
   logic       v_b, rdy_b, ov_b, ordy_b, sat_b;
   logic [7:0] d1_b, d2_b, ang_b;
   logic [1:0] dir_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   s1_a = 0, s2_a = 0, c_a = 0;
   bit   rand_rdy = 1'b0;

   always #5 CLK = ~CLK;

   orientation_filter #(.DW(8), .AVG_LOG2(2), .DEADBAND(0)) dut_a (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(v_a), .IN_READY(rdy_a),
      .DIST1(d1_a), .DIST2(d2_a), .OUT_VALID(ov_a), .OUT_READY(ordy_a),
      .ANGLE(ang_a), .DIRECTION(dir_a), .SATURATED(sat_a)
   );

   orientation_filter #(.DW(8), .AVG_LOG2(0), .DEADBAND(2)) dut_b (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(v_b), .IN_READY(rdy_b),
      .DIST1(d1_b), .DIST2(d2_b), .OUT_VALID(ov_b), .OUT_READY(ordy_b),
      .ANGLE(ang_b), .DIRECTION(dir_b), .SATURATED(sat_b)
   );

   // Reference: average of n pairs, heading error angle in whole degrees.
   function automatic exp_t model(input int s1, input int s2, input int n, input int db);
      exp_t e;
      int   a1, a2, x;
      a1 = s1 / n;
      a2 = s2 / n;
      x  = (a1 > a2) ? a1 - a2 : a2 - a1;
      e.dir = (a1 < a2) ? 1 : (a1 > a2) ? 2 : 0;
      if (x <= db) begin
         x     = 0;
         e.dir = 0;
      end
      e.sat   = (x > 70) ? 1 : 0;
      e.angle = (x > 70) ? 68 :
                $rtoi($atan(real'(x) / 28.0) * 180.0 / 3.141592653589793 + 0.5);
      return e;
   endfunction

   function automatic int near(input int base);
      int v;
      v = base + int'($urandom_range(0, 160)) - 80;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Input side: every accepted pair feeds the model.
   always @(negedge CLK) begin
      #1;
      if (RST_N && v_a && rdy_a) begin
         s1_a += int'(d1_a);
         s2_a += int'(d2_a);
         c_a++;
         if (c_a == 4) begin
            q_a.push_back(model(s1_a, s2_a, 4, 0));
            s1_a = 0;
            s2_a = 0;
            c_a  = 0;
         end
      end
      if (RST_N && v_b && rdy_b)
         q_b.push_back(model(int'(d1_b), int'(d2_b), 1, 2));
   end

   // Output side: compare on each completed handshake.
   always @(negedge CLK) begin
      #1;
      if (RST_N && ov_a) begin
         check("A output has scoreboard entry", int'(q_a.size() > 0), 1);
         if (ordy_a && q_a.size() > 0) begin
            e_a = q_a.pop_front();
            check("A angle", ang_a, e_a.angle);
            check("A direction", dir_a, e_a.dir);
            check("A saturated", sat_a, e_a.sat);
         end
      end
      if (RST_N && ov_b) begin
         check("B output has scoreboard entry", int'(q_b.size() > 0), 1);
         if (ordy_b && q_b.size() > 0) begin
            e_b = q_b.pop_front();
            check("B angle", ang_b, e_b.angle);
            check("B direction", dir_b, e_b.dir);
            check("B saturated", sat_b, e_b.sat);
         end
      end
   end

   always @(negedge CLK) begin
      if (rand_rdy) begin
         ordy_a = 1'($urandom_range(0, 1));
         ordy_b = 1'($urandom_range(0, 1));
      end
   end

   task automatic send_a(input int a, input int b);
      int g = 0;
      d1_a = 8'(a);
      d2_a = 8'(b);
      v_a  = 1'b1;
      #1;
      while (!rdy_a && g < 300) begin
         @(negedge CLK);
         g++;
      end
      check("A in_ready wait", rdy_a, 1);
      @(negedge CLK);
      v_a = 1'b0;
   endtask

   task automatic send_b(input int a, input int b);
      int g = 0;
      d1_b = 8'(a);
      d2_b = 8'(b);
      v_b  = 1'b1;
      #1;
      while (!rdy_b && g < 300) begin
         @(negedge CLK);
         g++;
      end
      check("B in_ready wait", rdy_b, 1);
      @(negedge CLK);
      v_b = 1'b0;
   endtask

   task automatic wait_drain();
      int g = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && g < 2000) begin
         @(negedge CLK);
         g++;
      end
      check("scoreboard drained", q_a.size() + q_b.size(), 0);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      RST_N = 1'b0;
      v_a = 1'b0; d1_a = 8'd0; d2_a = 8'd0; ordy_a = 1'b0;
      v_b = 1'b0; d1_b = 8'd0; d2_b = 8'd0; ordy_b = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      check("reset A in_ready", rdy_a, 0);
      check("reset A out_valid", ov_a, 0);
      check("reset A angle", ang_a, 0);
      check("reset A direction", dir_a, 0);
      check("reset A saturated", sat_a, 0);
      check("reset B in_ready", rdy_b, 0);
      check("reset B out_valid", ov_b, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      // basic estimate and latency
      ordy_a = 1'b1;
      repeat (4) send_a(10, 20);
      #1;
      check("A valid at E0", ov_a, 0);
      @(negedge CLK); #1;
      check("A valid at E1", ov_a, 0);
      @(negedge CLK); #1;
      check("A valid at E2", ov_a, 1);
      check("A basic angle", ang_a, 20);
      check("A basic direction", dir_a, 1);
      check("A basic saturated", sat_a, 0);
      @(negedge CLK); #1;
      check("A one-cycle valid", ov_a, 0);
      check("A held angle", ang_a, 20);
      check("A ready after handshake", rdy_a, 1);

      // reset mid-accumulation discards partial sums
      send_a(1, 200);
      send_a(1, 200);
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      check("mid reset angle", ang_a, 0);
      check("mid reset direction", dir_a, 0);
      check("mid reset out_valid", ov_a, 0);
      check("mid reset in_ready", rdy_a, 0);
      s1_a = 0; s2_a = 0; c_a = 0;
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (4) send_a(30, 30);
      wait_drain();

      // truncating average
      send_a(50, 22);
      repeat (3) send_a(51, 22);
      wait_drain();

      // saturation and deadband on the single-pair instance
      ordy_b = 1'b1;
      send_b(0, 70);
      send_b(0, 71);
      send_b(255, 0);
      send_b(40, 42);
      send_b(40, 43);
      wait_drain();

      // backpressure in HOLD
      ordy_a = 1'b0;
      repeat (4) send_a(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      g = 0;
      while (!ov_a && g < 20) begin
         @(negedge CLK); #1;
         g++;
      end
      check("A backpressure valid", ov_a, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         v_a  = (i % 2 == 0);
         d1_a = 8'd0;
         d2_a = 8'd100;
         #1;
         check("A hold in_ready", rdy_a, 0);
         check("A hold out_valid", ov_a, 1);
         if (q_a.size() > 0) begin
            check("A hold angle", ang_a, q_a[0].angle);
            check("A hold direction", dir_a, q_a[0].dir);
         end
      end
      @(negedge CLK);
      v_a    = 1'b0;
      ordy_a = 1'b1;
      @(negedge CLK); #1;
      check("A released valid", ov_a, 0);
      check("A released in_ready", rdy_a, 1);
      wait_drain();

      // randomized traffic with random consumer stalls
      rand_rdy = 1'b1;
      fork
         begin
            for (int i = 0; i < 120; i++) begin
               int p;
               p = int'($urandom_range(0, 255));
               send_a(p, near(p));
            end
         end
         begin
            for (int j = 0; j < 60; j++) begin
               int r;
               r = int'($urandom_range(0, 255));
               send_b(r, near(r));
            end
         end
      join
      rand_rdy = 1'b0;
      @(negedge CLK);
      ordy_a = 1'b1;
      ordy_b = 1'b1;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/orientation_filter.md
# orientation_filter

Next-generation orientation estimator for the navigation system. It takes paired readings from the two side-facing range sensors and averages 2^AVG_LOG2 pairs per estimate. It converts the absolute averaged difference to a heading-error angle through a fixed arctangent table, saturates out-of-range differences instead of flagging bad data, and applies a deadband to suppress direction chatter. It sits between the range-sensor front end (valid/ready source) and the steering/arm controller (valid/ready sink).

## Interface
- DW, 8: width of DIST1/DIST2 in sensor units (cm); legal 8..16.
- AVG_LOG2, 2: log2 of the number of sample pairs averaged per estimate; legal 0..4 (0 means no averaging).
- DEADBAND, 0: averaged differences ≤ DEADBAND are reported as zero angle, DIRECTION 00; legal 0..70.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- IN_VALID  in  1  DIST1/DIST2 pair present.
- IN_READY  out  1  block accepts a pair this cycle.
- DIST1  in  DW  sensor 1 distance.
- DIST2  in  DW  sensor 2 distance.
- OUT_VALID  out  1  result held on ANGLE/DIRECTION/SATURATED.
- OUT_READY  in  1  consumer takes the result.
- ANGLE  out  8  heading error magnitude, degrees, 0..68.
- DIRECTION  out  2  00 aligned, 01 DIST1<DIST2, 10 DIST1>DIST2; 11 never driven.
- SATURATED  out  1  averaged difference exceeded 70.

## Operation
- FSM states: ACCUM, DIFF, LOOKUP, HOLD. Reset state is ACCUM.
- **ACCUM**
  - IN_READY = 1.
  - Each accepted pair (IN_VALID & IN_READY) adds DIST1 to ACC1 and DIST2 to ACC2. Both accumulators are DW+AVG_LOG2 bits wide and cannot overflow.
  - Sample counter is AVG_LOG2 bits (1 bit when AVG_LOG2 = 0).
  - On the 2^AVG_LOG2-th accepted pair, go to DIFF.
  - IN_VALID while IN_READY = 0 is ignored; nothing is stored.
- **DIFF**
  - AVG1 = ACC1 >> AVG_LOG2, AVG2 = ACC2 >> AVG_LOG2 (truncating).
  - Register X = |AVG1 − AVG2| (DW bits) and a direction code: AVG1 < AVG2 → 01; AVG1 > AVG2 → 10; equal → 00.
  - If X ≤ DEADBAND, force X = 0 and direction = 00.
  - Go to LOOKUP.
- **LOOKUP**
  - For X ≤ 70: ANGLE = round(atan(X/28)) in degrees, implemented as a constant 71-entry table. Anchor values: 0→0, 1→2, 10→20, 11→21, 28→45, 34→51, 35→51, 56→63, 70→68. SATURATED = 0.
  - For X > 70: ANGLE = 68, SATURATED = 1.
  - ANGLE, DIRECTION, SATURATED and OUT_VALID = 1 are all registered at the same edge.
  - Go to HOLD.
- **HOLD**
  - OUT_VALID = 1; IN_READY = 0.
  - On OUT_READY = 1: OUT_VALID clears, ACC1/ACC2 and the counter clear, go to ACCUM.
- Outputs change only at the LOOKUP→HOLD edge. After the handshake they keep the last result with OUT_VALID = 0.
- **Reset** (RST_N low at any edge, including mid-accumulation or in HOLD):
  - State → ACCUM; ACC1, ACC2 and counter → 0; any partial average is discarded.
  - ANGLE = 0, DIRECTION = 00, SATURATED = 0, OUT_VALID = 0.
  - IN_READY = 0 while RST_N is low.

## Timing
- IN_READY is decoded from the state register (and RST_N). There is no combinational path from IN_VALID or OUT_READY to any output.
- Final pair accepted at edge E0 → DIFF during the next cycle → LOOKUP → OUT_VALID high after edge E2. Latency is 2 cycles from the final accept edge.
- Minimum period per estimate: 2^AVG_LOG2 + 3 cycles with IN_VALID and OUT_READY held high.
- IN_READY rises the cycle after the OUT_VALID/OUT_READY handshake edge.
- If OUT_READY is already high when HOLD is entered, OUT_VALID is high for exactly one cycle.
- Back-to-back IN_VALID at the HOLD→ACCUM transition: the first pair accepted is the one presented while IN_READY = 1. No pair is double-counted.

## Test plan
- Reset mid-accumulation (AVG_LOG2 = 2): accept 2 pairs, pull RST_N low for 3 cycles → ANGLE = 0, DIRECTION = 00, OUT_VALID = 0. The next 4 pairs (30,30) give ANGLE = 0, DIRECTION = 00, with no contribution from the discarded pairs.
- Basic estimate (AVG_LOG2 = 2, DEADBAND = 0): 4 pairs (10,20) → X = 10, ANGLE = 20, DIRECTION = 01, SATURATED = 0, OUT_VALID high 2 cycles after the 4th accept edge.
- Truncating average: DIST1 = 50,51,51,51, DIST2 = 22 ×4 → AVG1 = 50, X = 28, ANGLE = 45, DIRECTION = 10.
- Saturation boundary (DW = 8):
  - (0,70) → ANGLE = 68, SATURATED = 0.
  - (0,71) → ANGLE = 68, SATURATED = 1, DIRECTION = 01.
  - (255,0) → ANGLE = 68, SATURATED = 1, DIRECTION = 10.
- Deadband (DEADBAND = 2, AVG_LOG2 = 0): (40,42) → ANGLE = 0, DIRECTION = 00. (40,43) → ANGLE = 6, DIRECTION = 01.
- Backpressure: hold OUT_READY low 10 cycles in HOLD while pulsing IN_VALID with (0,100) → outputs stable, IN_READY = 0, pulses ignored. Raising OUT_READY gives one handshake, and IN_READY = 1 the following cycle.
